// File: rtl/llm_outlier_col_scan.sv
// Frame-buffering per-column outlier detector: buffers IN_DEPTH tiles, builds a
// column outlier mask over the whole frame, then replays the frame with the mask.
module llm_outlier_col_scan #(
  parameter int IN_WIDTH           = 16,
  parameter int IN_SIZE            = 4,
  parameter int IN_PARALLELISM     = 5,
  parameter int IN_DEPTH           = 3,
  parameter int MAX_LARGE_COLUMNS  = 2,
  parameter int LARGE_NUMBER_THRES = 127
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [IN_PARALLELISM*IN_SIZE*IN_WIDTH-1:0]   data_in,
  input  logic                                         data_in_valid,
  output logic                                         data_in_ready,
  output logic [IN_PARALLELISM*IN_SIZE*IN_WIDTH-1:0]   data_out,
  output logic [IN_SIZE-1:0]                           col_mask,
  output logic [$clog2(IN_SIZE+1)-1:0]                 col_count,
  output logic                                         mask_overflow,
  output logic                                         data_out_last,
  output logic                                         data_out_valid,
  input  logic                                         data_out_ready
);

  localparam int NUM_ELEMS = IN_PARALLELISM * IN_SIZE;
  localparam int TILE_W    = NUM_ELEMS * IN_WIDTH;
  localparam int CNT_W     = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int COUNT_W   = $clog2(IN_SIZE + 1);

  localparam logic [CNT_W-1:0]    LAST_IDX   = CNT_W'(IN_DEPTH - 1);
  localparam logic [IN_WIDTH:0]   THRES_EXT  = (IN_WIDTH + 1)'(LARGE_NUMBER_THRES);
  localparam logic [COUNT_W-1:0]  MAX_COLS   = COUNT_W'(MAX_LARGE_COLUMNS);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t               state_reg;
  logic [CNT_W-1:0]     wr_cnt_reg;
  logic [CNT_W-1:0]     rd_cnt_reg;
  logic [IN_SIZE-1:0]   mask_acc_reg;
  logic [IN_SIZE-1:0]   col_mask_reg;
  logic [COUNT_W-1:0]   col_count_reg;
  logic                 overflow_reg;
  logic                 out_valid_reg;
  logic                 out_last_reg;

  logic [TILE_W-1:0]    buffer [IN_DEPTH];

  logic [NUM_ELEMS-1:0] elem_hit;
  logic [IN_SIZE-1:0]   col_hit;
  logic [IN_SIZE-1:0]   final_mask;
  logic [IN_SIZE-1:0]   kept_mask;
  logic [COUNT_W-1:0]   kept_count;
  logic [COUNT_W-1:0]   final_pop;
  logic                 over_next;
  logic                 in_fire;
  logic                 out_fire;

  genvar gi, gr;

  // Magnitude is taken one bit wider so the most negative code still compares as large.
  generate
    for (gi = 0; gi < NUM_ELEMS; gi++) begin : g_elem
      logic [IN_WIDTH-1:0] x;
      logic [IN_WIDTH:0]   ext;
      logic [IN_WIDTH:0]   mag;
      assign x   = data_in[gi*IN_WIDTH +: IN_WIDTH];
      assign ext = {x[IN_WIDTH-1], x};
      assign mag = x[IN_WIDTH-1] ? (~ext + 1'b1) : ext;
      assign elem_hit[gi] = (mag > THRES_EXT);
    end

    for (gi = 0; gi < IN_SIZE; gi++) begin : g_col
      logic [IN_PARALLELISM-1:0] rows;
      for (gr = 0; gr < IN_PARALLELISM; gr++) begin : g_row
        assign rows[gr] = elem_hit[gr*IN_SIZE + gi];
      end
      assign col_hit[gi] = |rows;
    end
  endgenerate

  assign final_mask = mask_acc_reg | col_hit;

  // Keep the lowest-index qualifying columns up to the cap; flag anything beyond it.
  always_comb begin
    kept_mask  = '0;
    kept_count = '0;
    final_pop  = '0;
    for (int c = 0; c < IN_SIZE; c++) begin
      if (final_mask[c]) begin
        final_pop = final_pop + COUNT_W'(1);
        if (kept_count < MAX_COLS) begin
          kept_mask[c] = 1'b1;
          kept_count   = kept_count + COUNT_W'(1);
        end
      end
    end
    over_next = (final_pop > MAX_COLS);
  end

  assign data_in_ready = rst && (state_reg == FILL);
  assign in_fire       = data_in_valid && data_in_ready;
  assign out_fire      = out_valid_reg && data_out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= FILL;
      wr_cnt_reg    <= '0;
      rd_cnt_reg    <= '0;
      mask_acc_reg  <= '0;
      col_mask_reg  <= '0;
      col_count_reg <= '0;
      overflow_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end else begin
      unique case (state_reg)
        FILL: begin
          if (in_fire) begin
            if (wr_cnt_reg == LAST_IDX) begin
              col_mask_reg  <= kept_mask;
              col_count_reg <= kept_count;
              overflow_reg  <= over_next;
              wr_cnt_reg    <= '0;
              mask_acc_reg  <= '0;
              rd_cnt_reg    <= '0;
              out_valid_reg <= 1'b1;
              out_last_reg  <= (LAST_IDX == '0);
              state_reg     <= DRAIN;
            end else begin
              wr_cnt_reg   <= wr_cnt_reg + CNT_W'(1);
              mask_acc_reg <= final_mask;
            end
          end
        end
        DRAIN: begin
          if (out_fire) begin
            if (out_last_reg) begin
              rd_cnt_reg    <= '0;
              out_valid_reg <= 1'b0;
              out_last_reg  <= 1'b0;
              state_reg     <= FILL;
            end else begin
              rd_cnt_reg   <= rd_cnt_reg + CNT_W'(1);
              out_last_reg <= ((rd_cnt_reg + CNT_W'(1)) == LAST_IDX);
            end
          end
        end
        default: state_reg <= FILL;
      endcase
    end
  end

  // Frame storage carries no reset; stale contents are never presented as valid.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      buffer[wr_cnt_reg] <= data_in;
    end
  end

  assign data_out       = buffer[rd_cnt_reg];
  assign col_mask       = col_mask_reg;
  assign col_count      = col_count_reg;
  assign mask_overflow  = overflow_reg;
  assign data_out_last  = out_last_reg;
  assign data_out_valid = out_valid_reg;

endmodule

// File: tb/tb_llm_outlier_col_scan.sv
// Directed self-checking bench for llm_outlier_col_scan with default parameters.
module tb_llm_outlier_col_scan;

  localparam int W      = 16;
  localparam int SIZE   = 4;
  localparam int PAR    = 5;
  localparam int DEPTH  = 3;
  localparam int NE     = PAR * SIZE;
  localparam int TILE_W = NE * W;

  logic              clk = 1'b0;
  logic              rst;
  logic [TILE_W-1:0] data_in;
  logic              data_in_valid;
  logic              data_in_ready;
  logic [TILE_W-1:0] data_out;
  logic [SIZE-1:0]   col_mask;
  logic [2:0]        col_count;
  logic              mask_overflow;
  logic              data_out_last;
  logic              data_out_valid;
  logic              data_out_ready;

  int checks   = 0;
  int failures = 0;

  logic [TILE_W-1:0] cur_frame [DEPTH];

  llm_outlier_col_scan dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .col_mask       (col_mask),
    .col_count      (col_count),
    .mask_overflow  (mask_overflow),
    .data_out_last  (data_out_last),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [TILE_W-1:0] obs, input logic [TILE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Background pattern: every element lies in [-100, 99], so no element is an outlier.
  task automatic load_base(input int seed);
    for (int b = 0; b < DEPTH; b++) begin
      for (int i = 0; i < NE; i++) begin
        cur_frame[b][i*W +: W] = 16'(((seed + b*37 + i*11) % 200) - 100);
      end
    end
  endtask

  task automatic load_zero();
    for (int b = 0; b < DEPTH; b++) cur_frame[b] = '0;
  endtask

  task automatic set_elem(input int b, input int row, input int col, input int val);
    cur_frame[b][(row*SIZE + col)*W +: W] = 16'(val);
  endtask

  task automatic send_beats(input int n);
    for (int b = 0; b < n; b++) begin
      data_in       = cur_frame[b];
      data_in_valid = 1'b1;
      check($sformatf("fill_ready_b%0d", b), TILE_W'(data_in_ready), TILE_W'(1));
      check($sformatf("fill_ovalid_b%0d", b), TILE_W'(data_out_valid), TILE_W'(0));
      step();
      $display("IN  beat=%0d accepted", b);
    end
    data_in_valid = 1'b0;
    data_in       = '0;
  endtask

  task automatic recv_frame(input string name, input logic [3:0] emask, input int ecount,
                            input logic eovf, input bit toggle);
    for (int b = 0; b < DEPTH; b++) begin
      if (toggle) begin
        data_out_ready = 1'b0;
        step();
        check($sformatf("%s_hold_valid_b%0d", name, b), TILE_W'(data_out_valid), TILE_W'(1));
        check($sformatf("%s_hold_data_b%0d", name, b), data_out, cur_frame[b]);
        check($sformatf("%s_hold_last_b%0d", name, b), TILE_W'(data_out_last), TILE_W'(b == DEPTH-1));
        check($sformatf("%s_hold_mask_b%0d", name, b), TILE_W'(col_mask), TILE_W'(emask));
      end
      data_out_ready = 1'b1;
      check($sformatf("%s_valid_b%0d", name, b), TILE_W'(data_out_valid), TILE_W'(1));
      check($sformatf("%s_data_b%0d", name, b), data_out, cur_frame[b]);
      check($sformatf("%s_mask_b%0d", name, b), TILE_W'(col_mask), TILE_W'(emask));
      check($sformatf("%s_count_b%0d", name, b), TILE_W'(col_count), TILE_W'(ecount));
      check($sformatf("%s_ovf_b%0d", name, b), TILE_W'(mask_overflow), TILE_W'(eovf));
      check($sformatf("%s_last_b%0d", name, b), TILE_W'(data_out_last), TILE_W'(b == DEPTH-1));
      check($sformatf("%s_inready_b%0d", name, b), TILE_W'(data_in_ready), TILE_W'(0));
      $display("OUT %s beat=%0d mask=%b count=%0d ovf=%b last=%b",
               name, b, col_mask, col_count, mask_overflow, data_out_last);
      step();
      if (toggle) data_out_ready = 1'b0;
    end
    check($sformatf("%s_post_inready", name), TILE_W'(data_in_ready), TILE_W'(1));
    check($sformatf("%s_post_ovalid", name), TILE_W'(data_out_valid), TILE_W'(0));
    data_out_ready = 1'b1;
  endtask

  initial begin
    rst            = 1'b0;
    data_in        = '0;
    data_in_valid  = 1'b0;
    data_out_ready = 1'b1;
    step();
    step();
    check("rst_inready", TILE_W'(data_in_ready), TILE_W'(0));
    check("rst_ovalid",  TILE_W'(data_out_valid), TILE_W'(0));
    check("rst_last",    TILE_W'(data_out_last), TILE_W'(0));
    check("rst_mask",    TILE_W'(col_mask), TILE_W'(0));
    check("rst_count",   TILE_W'(col_count), TILE_W'(0));
    check("rst_ovf",     TILE_W'(mask_overflow), TILE_W'(0));
    rst = 1'b1;
    #1;
    check("rel_inready", TILE_W'(data_in_ready), TILE_W'(1));
    step();

    // Zero frame.
    load_zero();
    send_beats(DEPTH);
    recv_frame("zero", 4'b0000, 0, 1'b0, 1'b0);

    // Single 128 at row 4, col 2 in beat 1.
    load_base(3);
    set_elem(1, 4, 2, 128);
    send_beats(DEPTH);
    recv_frame("single", 4'b0100, 1, 1'b0, 1'b0);

    // Threshold boundary: 127/-127 are not outliers; -128 and -32768 are.
    load_base(7);
    set_elem(0, 0, 0, 127);
    set_elem(1, 1, 0, -127);
    set_elem(2, 0, 1, -128);
    set_elem(0, 0, 3, -32768);
    send_beats(DEPTH);
    recv_frame("thres", 4'b1010, 2, 1'b0, 1'b0);

    // Three qualifying columns, capped to the two lowest.
    load_base(11);
    set_elem(0, 0, 0, 300);
    set_elem(1, 0, 1, -200);
    set_elem(2, 1, 3, 1000);
    send_beats(DEPTH);
    recv_frame("ovf", 4'b0011, 2, 1'b1, 1'b0);

    // Backpressure toggling, then a clean frame to confirm the mask starts fresh.
    load_base(19);
    set_elem(2, 3, 0, -500);
    send_beats(DEPTH);
    recv_frame("toggle1", 4'b0001, 1, 1'b0, 1'b1);
    load_base(23);
    send_beats(DEPTH);
    recv_frame("toggle2", 4'b0000, 0, 1'b0, 1'b1);

    // Reset after two accepted beats of a col-1 outlier frame.
    load_base(29);
    set_elem(0, 2, 1, 999);
    send_beats(2);
    rst = 1'b0;
    step();
    check("mid_rst_inready", TILE_W'(data_in_ready), TILE_W'(0));
    check("mid_rst_ovalid",  TILE_W'(data_out_valid), TILE_W'(0));
    check("mid_rst_last",    TILE_W'(data_out_last), TILE_W'(0));
    check("mid_rst_mask",    TILE_W'(col_mask), TILE_W'(0));
    check("mid_rst_count",   TILE_W'(col_count), TILE_W'(0));
    check("mid_rst_ovf",     TILE_W'(mask_overflow), TILE_W'(0));
    rst = 1'b1;
    #1;
    load_base(31);
    set_elem(0, 0, 3, 200);
    send_beats(DEPTH);
    recv_frame("after_rst", 4'b1000, 1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
